// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - captures button release ticks and presents them round-robin over valid/ack
// Optional dropped-event counter port ovr_count is enabled by defining BTN_EVT_OVR_CNT_EN.
module button_event_queue #(
    parameter int N_BTN = 4,
    parameter int W_IDX = 2
) (
    input  logic             clkr,
    input  logic             resetr,
    input  logic [N_BTN-1:0] tickr_in,
    output logic             ev_valid,
    output logic [W_IDX-1:0] ev_idx,
    input  logic             ev_ack,
    output logic [N_BTN-1:0] pending,
    output logic             overrun,
    input  logic             ovr_clr
`ifdef BTN_EVT_OVR_CNT_EN
    ,
    output logic [7:0]       ovr_count
`endif
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state, state_n;
    logic             ev_valid_n;
    logic [W_IDX-1:0] ev_idx_n;
    logic [W_IDX-1:0] rr_ptr, rr_ptr_n;
    logic [N_BTN-1:0] clr, ovr_vec, pending_n;
    logic [N_BTN-1:0] rot_pend;
    logic [W_IDX-1:0] pick_off, pick_idx;
    logic [W_IDX:0]   pick_sum, next_sum;
    logic             pick_found;

    always_comb begin
        clr       = '0;
        ovr_vec   = '0;
        pending_n = '0;
        for (int i = 0; i < N_BTN; i++) begin
            clr[i]       = ev_valid & ev_ack & (ev_idx == W_IDX'(i));
            ovr_vec[i]   = tickr_in[i] & pending[i] & ~clr[i];
            pending_n[i] = (pending[i] & ~clr[i]) | tickr_in[i];
        end
    end

    // Rotate so bit k of rot_pend is button (rr_ptr + k) mod N_BTN; lowest set bit wins.
    always_comb begin
        rot_pend   = N_BTN'({pending, pending} >> rr_ptr);
        pick_found = |pending;
        pick_off   = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (rot_pend[k]) pick_off = W_IDX'(k);
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (W_IDX+1)'(N_BTN)) pick_sum = pick_sum - (W_IDX+1)'(N_BTN);
        pick_idx = pick_sum[W_IDX-1:0];
        next_sum = {1'b0, ev_idx} + (W_IDX+1)'(1);
        if (next_sum >= (W_IDX+1)'(N_BTN)) next_sum = '0;
    end

    always_comb begin
        state_n    = state;
        ev_valid_n = ev_valid;
        ev_idx_n   = ev_idx;
        rr_ptr_n   = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n    = PRESENT;
                    ev_valid_n = 1'b1;
                    ev_idx_n   = pick_idx;
                end
            end
            PRESENT: begin
                if (ev_ack) begin
                    state_n    = IDLE;
                    ev_valid_n = 1'b0;
                    rr_ptr_n   = next_sum[W_IDX-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clkr) begin
        if (resetr) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_idx   <= '0;
            rr_ptr   <= '0;
            pending  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            ev_valid <= ev_valid_n;
            ev_idx   <= ev_idx_n;
            rr_ptr   <= rr_ptr_n;
            pending  <= pending_n;
            if (|ovr_vec)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

`ifdef BTN_EVT_OVR_CNT_EN
    logic [3:0] ovr_num;
    logic [8:0] cnt_sum;

    always_comb begin
        ovr_num = '0;
        for (int i = 0; i < N_BTN; i++) begin
            ovr_num = ovr_num + 4'(ovr_vec[i]);
        end
        cnt_sum = {1'b0, ovr_count} + 9'(ovr_num);
    end

    // A clear in the same cycle as new overruns restarts from this cycle's count.
    always_ff @(posedge clkr) begin
        if (resetr)
            ovr_count <= '0;
        else if (ovr_clr)
            ovr_count <= 8'(ovr_num);
        else if (cnt_sum[8])
            ovr_count <= 8'hFF;
        else
            ovr_count <= cnt_sum[7:0];
    end
`endif

endmodule
